// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_pkg
//  Description : Shared constants and FSM state encoding for the
//                multiply/divide units (non-restoring divider).
//  Revision    : 1.0 - initial release
// ============================================================================
package multdiv_pkg;

  localparam int WIDTH      = 32;  // operand / result width
  localparam int ITERATIONS = 32;  // non-restoring steps per division
  localparam int CNT_W      = 5;   // iteration counter width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage
`default_nettype wire

// File: rtl/cla_addsub_32.sv
`default_nettype none
// ============================================================================
//  Module      : cla_addsub_32
//  Description : Add/subtract of an unsigned magnitude to/from a signed
//                (WIDTH+1)-bit partial remainder. The low WIDTH bits go
//                through a 4-bit-group carry-lookahead adder; the extra sign
//                bit is completed from the final group carry.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_addsub_32 #(
  parameter int WIDTH = multdiv_pkg::WIDTH
) (
  input  logic [WIDTH:0]   a,    // signed partial remainder
  input  logic [WIDTH-1:0] b,    // unsigned divisor magnitude
  input  logic             sub,  // 1: a - b, 0: a + b
  output logic [WIDTH:0]   sum
);

  localparam int GROUPS = WIDTH / 4;

  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_s;
  logic [GROUPS:0]  w_gc;

  // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
  assign w_b     = b ^ {WIDTH{sub}};
  assign w_g     = a[WIDTH-1:0] & w_b;
  assign w_p     = a[WIDTH-1:0] ^ w_b;
  assign w_gc[0] = sub;

  generate
    for (genvar gi = 0; gi < GROUPS; gi++) begin : g_group
      logic [3:0] w_gg;
      logic [3:0] w_pp;
      logic [4:0] w_c;

      assign w_gg   = w_g[4*gi +: 4];
      assign w_pp   = w_p[4*gi +: 4];
      assign w_c[0] = w_gc[gi];
      assign w_c[1] = w_gg[0] | (w_pp[0] & w_c[0]);
      assign w_c[2] = w_gg[1] | (w_pp[1] & w_gg[0]) | (w_pp[1] & w_pp[0] & w_c[0]);
      assign w_c[3] = w_gg[2] | (w_pp[2] & w_gg[1]) | (w_pp[2] & w_pp[1] & w_gg[0])
                    | (w_pp[2] & w_pp[1] & w_pp[0] & w_c[0]);
      assign w_c[4] = w_gg[3] | (w_pp[3] & w_gg[2]) | (w_pp[3] & w_pp[2] & w_gg[1])
                    | (w_pp[3] & w_pp[2] & w_pp[1] & w_gg[0])
                    | (w_pp[3] & w_pp[2] & w_pp[1] & w_pp[0] & w_c[0]);

      assign w_gc[gi+1]       = w_c[4];
      assign w_s[4*gi +: 4]   = w_pp ^ w_c[3:0];
    end
  endgenerate

  // The magnitude's implicit sign bit is 0, so its (possibly inverted)
  // contribution to the top bit is just 'sub'.
  assign sum = {a[WIDTH] ^ sub ^ w_gc[GROUPS], w_s};

endmodule
`default_nettype wire

// File: rtl/div_nonrestoring_32.sv
`default_nettype none
// ============================================================================
//  Module      : div_nonrestoring_32
//  Description : Multi-cycle signed 32-bit non-restoring divider. Works on
//                operand magnitudes for 32 iterations, then corrects the
//                remainder and applies signs. Truncating quotient, remainder
//                takes the dividend's sign, divide-by-zero flagged.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_nonrestoring_32 #(
  parameter int WIDTH = multdiv_pkg::WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY
);

  import multdiv_pkg::*;

  div_state_t       r_state;
  div_state_t       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_rem;     // signed partial remainder, one guard bit
  logic [WIDTH-1:0] r_quo;     // dividend magnitude shifting out / quotient in
  logic [WIDTH-1:0] r_dvsr;    // divisor magnitude
  logic             r_qneg;
  logic             r_rneg;
  logic             r_div0;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_b_zero;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_add_a;
  logic             w_sub;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_rem_fix;
  logic [WIDTH-1:0] w_quo_signed;
  logic [WIDTH-1:0] w_rem_signed;
  logic             w_last_iter;

  // Magnitudes: the most negative value maps to itself, which is the
  // correct unsigned magnitude 2^(WIDTH-1).
  assign w_a_mag  = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_b_mag  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign w_b_zero = (data_operandB == '0);

  // Partial remainder always stays within [-|B|, |B|), so its top bit can be
  // dropped when shifting in the next dividend bit.
  assign w_shift     = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
  assign w_add_a     = (r_state == RUN) ? w_shift : r_rem;
  assign w_sub       = ~r_rem[WIDTH];
  assign w_last_iter = (r_cnt == CNT_W'(ITERATIONS - 1));

  cla_addsub_32 #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .a   (w_add_a),
    .b   (r_dvsr),
    .sub (w_sub),
    .sum (w_sum)
  );

  // In FIX a negative remainder selects add, so w_sum is r_rem + |B|.
  assign w_rem_fix    = r_rem[WIDTH] ? w_sum[WIDTH-1:0] : r_rem[WIDTH-1:0];
  assign w_quo_signed = r_qneg ? -r_quo : r_quo;
  assign w_rem_signed = r_rneg ? -w_rem_fix : w_rem_fix;
  assign data_resultRDY = (r_state == DONE);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a start strobe preempts whatever is in progress, and a
  // zero divisor skips the iterations and is resolved in FIX.
  always_comb begin
    w_state_next = r_state;
    if (ctrl_DIV) begin
      w_state_next = w_b_zero ? FIX : RUN;
    end else begin
      case (r_state)
        IDLE:    w_state_next = IDLE;
        RUN:     w_state_next = w_last_iter ? FIX : RUN;
        FIX:     w_state_next = DONE;
        DONE:    w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Datapath: operand capture, one non-restoring step per RUN cycle, and
  // the sign-corrected result registered in FIX.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt          <= '0;
      r_rem          <= '0;
      r_quo          <= '0;
      r_dvsr         <= '0;
      r_qneg         <= 1'b0;
      r_rneg         <= 1'b0;
      r_div0         <= 1'b0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
    end else if (ctrl_DIV) begin
      r_cnt          <= '0;
      r_rem          <= '0;
      r_quo          <= w_a_mag;
      r_dvsr         <= w_b_mag;
      r_qneg         <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      r_rneg         <= data_operandA[WIDTH-1];
      r_div0         <= w_b_zero;
      data_exception <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          r_rem <= w_sum;
          r_quo <= {r_quo[WIDTH-2:0], ~w_sum[WIDTH]};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        FIX: begin
          if (r_div0) begin
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b1;
          end else begin
            data_result    <= w_quo_signed;
            data_remainder <= w_rem_signed;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_nonrestoring_32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_nonrestoring_32
//  Description : Directed-vector bench for div_nonrestoring_32 with a
//                scoreboard queue and a decoupled completion monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_nonrestoring_32;

  logic        clock;
  logic        reset;
  logic        ctrl_DIV;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_exception;
  logic        data_resultRDY;

  typedef struct {
    logic [31:0] res;
    logic [31:0] rem;
    logic        exc;
    int          at_edge;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   edge_n   = 0;

  div_nonrestoring_32 #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (op_a),
    .data_operandB  (op_b),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Edge counter: at a negedge, edge_n is the number of the last rising edge.
  always @(posedge clock) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Completion monitor: every pulse must match the oldest expectation.
  always @(negedge clock) begin
    if (!reset && data_resultRDY) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rdy: pulse at edge %0d with nothing expected", edge_n);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result",    data_result,             e.res);
        check("remainder", data_remainder,          e.rem);
        check("exception", {31'b0, data_exception}, {31'b0, e.exc});
        check("rdy_edge",  edge_n,                  e.at_edge);
      end
    end
  end

  // Called at a negedge; the strobe is sampled at the next rising edge k.
  task automatic start_div(input logic [31:0] a, input logic [31:0] b, input bit push,
                           input logic [31:0] er, input logic [31:0] erm, input logic ee,
                           input int lat, output int k);
    exp_t e;
    ctrl_DIV = 1'b1;
    op_a     = a;
    op_b     = b;
    k        = edge_n + 1;
    if (push) begin
      e.res = er; e.rem = erm; e.exc = ee; e.at_edge = k + lat;
      sb.push_back(e);
    end
    @(negedge clock);
    ctrl_DIV = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout: %0d results outstanding after %0d cycles", sb.size(), budget);
      sb.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int k0;
    reset    = 1'b0;
    ctrl_DIV = 1'b0;
    op_a     = '0;
    op_b     = '0;
    #1 reset = 1'b1;
    ctrl_DIV = 1'b1;  // must be ignored while reset is high
    repeat (3) @(negedge clock);
    check("reset_result",    data_result,             32'h0);
    check("reset_remainder", data_remainder,          32'h0);
    check("reset_exception", {31'b0, data_exception}, 32'h0);
    check("reset_rdy",       {31'b0, data_resultRDY}, 32'h0);
    ctrl_DIV = 1'b0;
    reset    = 1'b0;
    @(negedge clock);

    // Basic signed vectors, nominal latency 33 edges after the start edge.
    start_div(32'd100,       32'd7,          1'b1, 32'd14,       32'd2,        1'b0, 33, k); wait_done(60);
    start_div(-32'sd100,     32'd7,          1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33, k); wait_done(60);
    start_div(32'd100,       -32'sd7,        1'b1, 32'hFFFFFFF2, 32'd2,        1'b0, 33, k); wait_done(60);
    start_div(-32'sd100,     -32'sd7,        1'b1, 32'd14,       32'hFFFFFFFE, 1'b0, 33, k); wait_done(60);
    start_div(32'h80000000,  32'hFFFFFFFF,   1'b1, 32'h80000000, 32'h0,        1'b0, 33, k); wait_done(60);
    start_div(32'h7FFFFFFF,  32'd1,          1'b1, 32'h7FFFFFFF, 32'h0,        1'b0, 33, k); wait_done(60);
    start_div(32'd0,         32'd5,          1'b1, 32'h0,        32'h0,        1'b0, 33, k); wait_done(60);
    start_div(32'h80000000,  32'd2,          1'b1, 32'hC0000000, 32'h0,        1'b0, 33, k); wait_done(60);
    start_div(32'd7,         32'h80000000,   1'b1, 32'h0,        32'd7,        1'b0, 33, k); wait_done(60);

    // Divide by zero: pulse one edge after the start, then nothing further.
    start_div(32'd5, 32'd0, 1'b1, 32'h0, 32'h0, 1'b1, 1, k); wait_done(10);
    repeat (40) @(negedge clock);
    check("div0_hold_exception", {31'b0, data_exception}, 32'h1);
    check("div0_hold_result",    data_result,             32'h0);

    // Restart mid-run: only the second division may complete.
    start_div(32'd100, 32'd7, 1'b0, 32'h0, 32'h0, 1'b0, 33, k0);
    while (edge_n + 1 < k0 + 10) @(negedge clock);
    start_div(32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 1'b0, 33, k);
    check("restart_edge", k, k0 + 10);
    wait_done(60);
    repeat (40) @(negedge clock);

    // Asynchronous reset between clock edges during RUN.
    start_div(32'd100, 32'd7, 1'b0, 32'h0, 32'h0, 1'b0, 33, k0);
    while (edge_n < k0 + 20) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("areset_result",    data_result,             32'h0);
    check("areset_remainder", data_remainder,          32'h0);
    check("areset_exception", {31'b0, data_exception}, 32'h0);
    check("areset_rdy",       {31'b0, data_resultRDY}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    start_div(32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, 33, k); wait_done(60);
    repeat (5) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
